// File: rtl/spi_slave_burst.sv
// SPI slave, WIDTH-bit words, all CPOL/CPHA modes, multi-word bursts per select.
// Define SPI_SLAVE_BURST_WCOUNT_EN to add the saturating wcount output.
module spi_slave_burst #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int SYNC      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             select,
  input  logic             mclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             start,
  output logic             done,
  output logic             busy,
  output logic             abort
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
  ,
  output logic [15:0]      wcount
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [SYNC-1:0]  mclk_q;
  logic [SYNC-1:0]  mosi_q;
  logic [SYNC-1:0]  sel_q;
  logic             mclk_prev_q;
  logic             sel_prev_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] tx_d;
  logic [WIDTH-1:0] rx_d;
  logic [CW-1:0]    cnt_q;

  logic mclk_s;
  logic mosi_s;
  logic sel_s;
  logic rise;
  logic fall;
  logic lead;
  logic trail;
  logic samp;
  logic shft;
  logic sel_rise;
  logic first_bit;
  logic next_bit;

  assign mclk_s   = mclk_q[SYNC-1];
  assign mosi_s   = mosi_q[SYNC-1];
  assign sel_s    = sel_q[SYNC-1];
  assign rise     = mclk_s & ~mclk_prev_q;
  assign fall     = ~mclk_s & mclk_prev_q;
  assign lead     = cpol_q ? fall : rise;
  assign trail    = cpol_q ? rise : fall;
  assign samp     = cpha_q ? trail : lead;
  assign shft     = cpha_q ? lead : trail;
  assign sel_rise = sel_s & ~sel_prev_q;

  always_comb begin
    rx_d = '0;
    tx_d = '0;
    if (LSB_FIRST != 0) begin
      rx_d = {mosi_s, rx_q[WIDTH-1:1]};
      tx_d = {1'b0, tx_q[WIDTH-1:1]};
    end else begin
      rx_d = {rx_q[WIDTH-2:0], mosi_s};
      tx_d = {tx_q[WIDTH-2:0], 1'b0};
    end
  end

  assign first_bit = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
  assign next_bit  = (LSB_FIRST != 0) ? tx_d[0] : tx_d[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk_q      <= '0;
      mosi_q      <= '0;
      sel_q       <= '0;
      mclk_prev_q <= 1'b0;
      sel_prev_q  <= 1'b0;
    end else begin
      mclk_q      <= {mclk_q[SYNC-2:0], mclk};
      mosi_q      <= {mosi_q[SYNC-2:0], mosi};
      sel_q       <= {sel_q[SYNC-2:0], select};
      mclk_prev_q <= mclk_s;
      sel_prev_q  <= sel_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      miso    <= 1'b0;
      dout    <= '0;
      start   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      abort   <= 1'b0;
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
      wcount  <= '0;
`endif
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (sel_rise) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            start   <= 1'b1;
            state_q <= LOAD;
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
            wcount  <= '0;
`endif
          end
        end
        LOAD: begin
          if (!sel_s) begin
            abort   <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            tx_q    <= din;
            rx_q    <= '0;
            miso    <= first_bit;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // A completing sample beats a simultaneous select drop.
          if (samp && cnt_q == LAST) begin
            rx_q    <= rx_d;
            dout    <= rx_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
            if (wcount != 16'hFFFF) wcount <= wcount + 16'd1;
`endif
          end else if (!sel_s) begin
            abort   <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (samp) begin
            rx_q  <= rx_d;
            cnt_q <= cnt_q + CW'(1);
          end else if (shft && cnt_q != '0) begin
            // cnt==0 shift edges: cpha=1 first lead, or stale trail of last word
            tx_q <= tx_d;
            miso <= next_bit;
          end
        end
        DONE: begin
          if (sel_s) begin
            start   <= 1'b1;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Scoreboard bench for spi_slave_burst: WIDTH=8 MSB-first and WIDTH=16 LSB-first
// instances share the SPI bus, each with its own select line.
module tb_spi_slave_burst;

  localparam int H   = 8;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic mclk = 1'b0;
  logic mosi = 1'b0;
  logic sel8 = 1'b0;
  logic sel16 = 1'b0;
  logic [7:0]  din8 = '0;
  logic [15:0] din16 = '0;

  logic        miso8, start8, done8, busy8, abort8;
  logic [7:0]  dout8;
  logic        miso16, start16, done16, busy16, abort16;
  logic [15:0] dout16;
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
  logic [15:0] wc8, wc16;
`endif

  always #5 clk = ~clk;

  spi_slave_burst #(.WIDTH(8), .LSB_FIRST(0), .SYNC(2)) u8 (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .select(sel8), .mclk(mclk), .mosi(mosi), .miso(miso8),
    .din(din8), .dout(dout8), .start(start8), .done(done8),
    .busy(busy8), .abort(abort8)
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
    , .wcount(wc8)
`endif
  );

  spi_slave_burst #(.WIDTH(16), .LSB_FIRST(1), .SYNC(2)) u16 (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .select(sel16), .mclk(mclk), .mosi(mosi), .miso(miso16),
    .din(din16), .dout(dout16), .start(start16), .done(done16),
    .busy(busy16), .abort(abort16)
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
    , .wcount(wc16)
`endif
  );

  typedef struct packed {
    logic [15:0] dout;
    logic [15:0] mrx;
  } exp_t;

  exp_t        exp8[$];
  exp_t        exp16[$];
  logic [15:0] got8[$];
  logic [15:0] got16[$];
  exp_t        e8, e16;
  logic [15:0] mws[4];
  logic [15:0] dws[4];

  int total = 0;
  int passed = 0;
  int n_start8 = 0, n_done8 = 0, n_abort8 = 0;
  int n_start16 = 0, n_done16 = 0, n_abort16 = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic miss(input string name);
    total++;
    $display("FAIL %s: done with no queued expectation", name);
  endtask

  // Monitor: pops the scoreboard whenever a slave reports a finished word.
  always @(negedge clk) begin
    if (!reset) begin
      if (start8) n_start8++;
      if (abort8) n_abort8++;
      if (start16) n_start16++;
      if (abort16) n_abort16++;
      if (done8) begin
        n_done8++;
        if (exp8.size() == 0 || got8.size() == 0) miss("u8_done");
        else begin
          e8 = exp8.pop_front();
          chk("u8_dout", 32'(dout8), 32'(e8.dout));
          chk("u8_master_rx", 32'(got8.pop_front()), 32'(e8.mrx));
          chk("u8_busy_at_done", 32'(busy8), 32'h0);
          chk("u8_abort_at_done", 32'(abort8), 32'h0);
        end
      end
      if (done16) begin
        n_done16++;
        if (exp16.size() == 0 || got16.size() == 0) miss("u16_done");
        else begin
          e16 = exp16.pop_front();
          chk("u16_dout", 32'(dout16), 32'(e16.dout));
          chk("u16_master_rx", 32'(got16.pop_front()), 32'(e16.mrx));
          chk("u16_busy_at_done", 32'(busy16), 32'h0);
          chk("u16_abort_at_done", 32'(abort16), 32'h0);
        end
      end
    end
  end

  task automatic set_sel(input int w, input logic v);
    if (w == 8) sel8 = v;
    else sel16 = v;
  endtask

  task automatic set_din(input int w, input logic [15:0] v);
    if (w == 8) din8 = v[7:0];
    else din16 = v;
  endtask

  function automatic logic get_miso(input int w);
    return (w == 8) ? miso8 : miso16;
  endfunction

  task automatic finish_word(input int w, input logic [15:0] rx,
                             input logic [15:0] nxt);
    if (w == 8) got8.push_back(rx);
    else got16.push_back(rx);
    set_din(w, nxt);
  endtask

  // Master side of one word; called on a negedge with select already high.
  task automatic xword(input int w, input bit lsb, input bit pol,
                       input bit pha, input logic [15:0] mw, input int nbits,
                       input bit last, input logic [15:0] nxt);
    logic [15:0] rx;
    int k;
    rx = '0;
    if (!pha) mosi = mw[lsb ? 0 : w-1];
    for (int i = 0; i < nbits; i++) begin
      k = lsb ? i : w-1-i;
      mclk = ~pol;
      if (pha) mosi = mw[k];
      else begin
        rx[k] = get_miso(w);
        if (i == w-1) finish_word(w, rx, nxt);
      end
      if (!pha && i == w-1 && last) begin
        @(negedge clk);
        mclk = pol;
        set_sel(w, 1'b0);
      end else begin
        repeat (H) @(negedge clk);
        mclk = pol;
        if (pha) begin
          rx[k] = get_miso(w);
          if (i == w-1) begin
            finish_word(w, rx, nxt);
            if (last) begin
              @(negedge clk);
              set_sel(w, 1'b0);
            end
          end
        end else if (i < w-1) begin
          mosi = mw[lsb ? i+1 : w-2-i];
        end
      end
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic burst(input int w, input bit lsb, input bit pol,
                       input bit pha, input int n, input bit tog);
    cpol = pol;
    cpha = pha;
    mclk = pol;
    set_din(w, dws[0]);
    repeat (8) @(negedge clk);
    set_sel(w, 1'b1);
    repeat (GAP) @(negedge clk);
    for (int j = 0; j < n; j++) begin
      if (w == 8) exp8.push_back({mws[j], dws[j]});
      else exp16.push_back({mws[j], dws[j]});
      xword(w, lsb, pol, pha, mws[j], w, j == n-1,
            (j+1 < n) ? dws[j+1] : 16'h0);
      if (tog && j == 0) cpha = ~cpha;
      if (j < n-1) repeat (GAP) @(negedge clk);
    end
    repeat (GAP) @(negedge clk);
  endtask

  int s8, d8, a8, s16, d16, a16;

  task automatic snap();
    s8 = n_start8; d8 = n_done8; a8 = n_abort8;
    s16 = n_start16; d16 = n_done16; a16 = n_abort16;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_u8", 32'({miso8, start8, done8, busy8, abort8, dout8}), 32'h0);
    chk("reset_u16", 32'({miso16, start16, done16, busy16, abort16, dout16}),
        32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      snap();
      mws[0] = 16'hA1;
      dws[0] = 16'hB2;
      burst(8, 1'b0, bit'((m >> 1) & 1), bit'(m & 1), 1, 1'b0);
      chk($sformatf("mode%0d_starts", m), 32'(n_start8 - s8), 32'd1);
      chk($sformatf("mode%0d_dones", m), 32'(n_done8 - d8), 32'd1);
      chk($sformatf("mode%0d_aborts", m), 32'(n_abort8 - a8), 32'd0);
      chk($sformatf("mode%0d_pending", m), 32'(exp8.size()), 32'd0);
    end

    snap();
    mws[0] = 16'h1234; mws[1] = 16'hABCD; mws[2] = 16'h0F0F;
    dws[0] = 16'h5555; dws[1] = 16'hAAAA; dws[2] = 16'h8001;
    burst(16, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    chk("burst16_starts", 32'(n_start16 - s16), 32'd3);
    chk("burst16_dones", 32'(n_done16 - d16), 32'd3);
    chk("burst16_aborts", 32'(n_abort16 - a16), 32'd0);
    chk("burst16_pending", 32'(exp16.size()), 32'd0);
    chk("burst16_u8_idle_starts", 32'(n_start8 - s8), 32'd0);
`ifdef SPI_SLAVE_BURST_WCOUNT_EN
    chk("burst16_wcount", 32'(wc16), 32'd3);
`endif

    snap();
    cpol = 1'b1; cpha = 1'b1; mclk = 1'b1; din8 = 8'h99;
    repeat (8) @(negedge clk);
    sel8 = 1'b1;
    repeat (GAP) @(negedge clk);
    xword(8, 1'b0, 1'b1, 1'b1, 16'h5A, 4, 1'b0, 16'h0);
    sel8 = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("abort_count", 32'(n_abort8 - a8), 32'd1);
    chk("abort_no_done", 32'(n_done8 - d8), 32'd0);
    chk("abort_dout_kept", 32'(dout8), 32'hA1);
    chk("abort_busy", 32'(busy8), 32'h0);
    snap();
    mws[0] = 16'h51; dws[0] = 16'h62;
    burst(8, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    chk("after_abort_dones", 32'(n_done8 - d8), 32'd1);
    chk("after_abort_pending", 32'(exp8.size()), 32'd0);

    cpol = 1'b0; cpha = 1'b1; mclk = 1'b0; din8 = 8'h77;
    repeat (8) @(negedge clk);
    sel8 = 1'b1;
    repeat (GAP) @(negedge clk);
    xword(8, 1'b0, 1'b0, 1'b1, 16'hE7, 5, 1'b0, 16'h0);
    chk("midword_busy", 32'(busy8), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_reset_u8", 32'({miso8, start8, done8, busy8, abort8, dout8}),
        32'h0);
    @(negedge clk);
    sel8 = 1'b0;
    mclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    snap();
    mws[0] = 16'h3C; dws[0] = 16'hC3;
    burst(8, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    chk("after_reset_dones", 32'(n_done8 - d8), 32'd1);
    chk("after_reset_pending", 32'(exp8.size()), 32'd0);

    snap();
    mws[0] = 16'h81; mws[1] = 16'h7E;
    dws[0] = 16'h7E; dws[1] = 16'h81;
    burst(8, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    chk("toggle_starts", 32'(n_start8 - s8), 32'd2);
    chk("toggle_dones", 32'(n_done8 - d8), 32'd2);
    chk("toggle_pending", 32'(exp8.size()), 32'd0);

    snap();
    cpol = 1'b0; cpha = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mclk = ~mclk;
      mosi = ~mosi;
      repeat (H) @(negedge clk);
    end
    repeat (GAP) @(negedge clk);
    chk("spurious_starts_u8", 32'(n_start8 - s8), 32'd0);
    chk("spurious_starts_u16", 32'(n_start16 - s16), 32'd0);
    chk("spurious_busy_u8", 32'(busy8), 32'h0);
    chk("spurious_miso_u8", 32'(miso8), 32'h1);
    chk("spurious_dout_u8", 32'(dout8), 32'h7E);
    chk("spurious_miso_u16", 32'(miso16), 32'h0);
    chk("spurious_dout_u16", 32'(dout16), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
- Parametrised successor of the 8-bit SPI slave: WIDTH-bit words, selectable bit order, and back-to-back multi-word bursts within one select assertion.
- All four CPOL/CPHA modes. Master-side mclk, mosi and select are oversampled and synchronised into the single system clock domain.
- Sits between an external SPI master and local register or FIFO logic. Handshakes per word via start/done strobes.

Parameters:
- WIDTH, 8, bits per word (2..32).
- LSB_FIRST, 0, 0 shifts MSB first, 1 shifts LSB first (both directions).
- SYNC, 2, synchroniser depth for mclk/mosi/select (>=2).

Ports:
- clk  in  1  system clock; must be at least 8x the mclk rate.
- reset  in  1  asynchronous, active-high reset.
- cpol  in  1  idle mclk level; sampled at select rise.
- cpha  in  1  0 samples on leading edge, 1 samples on trailing edge; sampled at select rise.
- select  in  1  active-high chip select from master.
- mclk  in  1  SPI clock from master.
- mosi  in  1  master-to-slave data.
- miso  out  1  slave-to-master data.
- din  in  WIDTH  word to send; must be valid in the cycle where start=1.
- dout  out  WIDTH  last complete received word; held until next done.
- start  out  1  one-cycle strobe: a new word begins, din requested.
- done  out  1  one-cycle strobe: dout valid, word complete.
- busy  out  1  word transfer in progress.
- abort  out  1  one-cycle strobe: select dropped mid-word.

Behaviour:
- Reset (async, any time, including mid-word) clears all of the following: miso=0, dout=0, start=0, done=0, busy=0, abort=0. Shift register and bit counter also clear. FSM returns to IDLE.
- Synchronisers: mclk, mosi and select each pass through SYNC flops. Edges are detected on the synchronised signals with one extra flop.
- Mode capture: cpol and cpha are latched on the synchronised select rise. Changes while selected are ignored.
- Edge definitions: leading edge = mclk transitions cpol -> ~cpol; trailing edge = the reverse.
  - Sample edge = leading if cpha=0, trailing if cpha=1.
  - Shift edge = the other edge.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Synchronised select rise -> LOAD. start=1 for exactly one cycle, SYNC+1 clk after the select rise.
- LOAD (1 cycle, start=1):
  - din is latched into the tx shift register on the clk edge ending the cycle.
  - miso presents the first bit: din[WIDTH-1], or din[0] if LSB_FIRST.
  - Bit counter is cleared; busy=1 from the next cycle. -> SHIFT.
- SHIFT:
  - Each sample edge shifts synchronised mosi into the rx register and increments the bit counter.
  - Each shift edge advances the tx register and updates miso.
  - cpha=1: the first leading edge is a shift edge, but miso already holds the first bit. That first shift edge in a word is therefore suppressed.
  - When the counter reaches WIDTH on a sample edge -> DONE.
  - Shift edges after the final sample edge are ignored (cpha=0 trailing edge).
- DONE (1 cycle):
  - dout <= rx register; done=1; busy=0 in the same cycle.
  - If select is still high, go to LOAD next cycle: start pulses, next word, burst continues. Otherwise go to IDLE.
  - Master must leave at least SYNC+3 clk between the final edge of one word and the next sample or shift edge.
- Select deasserted in LOAD/SHIFT (synchronised):
  - abort=1 for one cycle, busy=0, dout unchanged, no done. -> IDLE.
- Select deasserted in the same cycle as DONE: done wins, abort stays 0, then IDLE.
- Select while in IDLE with a spurious mclk edge: ignored.
- miso holds its last value when deselected; it is not tristated.

Optional Feature:
- SPI_SLAVE_BURST_WCOUNT_EN
- Defined: adds output wcount [15:0].
  - Cleared to 0 on reset and on each select rise.
  - Incremented in each DONE cycle; saturates at 16'hFFFF.
  - dout and wcount update in the same cycle.
- Undefined: port absent, no counter logic.

Test Plan:
- WIDTH=8, all four cpol/cpha modes, one word each: master sends 8'hA1, slave din=8'hB2 -> dout=8'hA1, master receives 8'hB2, one done, busy=0 at done, abort=0.
- WIDTH=16, LSB_FIRST=1, mode 0, burst of 3 words in one select: master sends 16'h1234, 16'hABCD, 16'h0F0F; slave din 16'h5555, 16'hAAAA, 16'h8001.
  - Expect 3 start and 3 done pulses, each dout matches in order, master receives the din words.
  - WCOUNT_EN builds: wcount=3.
- WIDTH=8, mode 3: drop select after 4 bits -> abort=1 once, no done, dout keeps previous 8'hA1. Next full transfer of 8'h51/8'h62 succeeds.
- Assert reset mid-word (bit 5, mode 1) -> all outputs 0 immediately (asynchronous). Following transfer of 8'h3C/8'hC3 is correct.
- Toggle cpha mid-burst while selected -> current burst keeps its latched mode. Data is correct for 2 words, 8'h81/8'h7E.
- Master mclk edges while select=0 -> no start, busy=0, miso unchanged, dout unchanged.
